// File: rtl/square_pkg.sv
// Shared types for the square/duty channel: envelope modes and channel states.
// Pure declarations; no latency or flow control involved.
package square_pkg;

    typedef enum logic [1:0] {
        ENV_CONST  = 2'd0,
        ENV_DECAY  = 2'd1,
        ENV_ATTACK = 2'd2
    } env_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/square_duty_env_if.sv
// Sequencer-side bundle of the square channel: config/control in, status and sample out.
// No handshake: start is a single-cycle strobe and outputs carry no backpressure.
interface square_duty_env_if #(
    parameter int PERIOD_W = 21,
    parameter int SAMPLE_W = 16,
    parameter int LEN_W    = 16
) ();
    logic                enable;
    logic                start;
    logic [PERIOD_W-1:0] full_period;
    logic [PERIOD_W-1:0] active_period;
    logic [SAMPLE_W-1:0] volume;
    logic [1:0]          env_mode;
    logic [SAMPLE_W-1:0] env_step;
    logic [LEN_W-1:0]    length;
    logic                busy;
    logic                done;
    logic [SAMPLE_W-1:0] square_wave;

    modport master (
        output enable, start, full_period, active_period, volume, env_mode, env_step, length,
        input  busy, done, square_wave
    );

    modport slave (
        input  enable, start, full_period, active_period, volume, env_mode, env_step, length,
        output busy, done, square_wave
    );
endinterface

// File: rtl/square_envelope.sv
// Amplitude register: loads on note start, steps once per waveform period with saturation.
// Latency 1 cycle from load/step_en to amp; no backpressure.
module square_envelope
    import square_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [1:0]          load_mode,
    input  logic [SAMPLE_W-1:0] load_vol,
    input  logic                step_en,
    input  logic [1:0]          mode,
    input  logic [SAMPLE_W-1:0] vol,
    input  logic [SAMPLE_W-1:0] step,
    output logic [SAMPLE_W-1:0] amp
);

    logic [SAMPLE_W-1:0] amp_q, amp_d;
    logic [SAMPLE_W-1:0] headroom;

    always_comb begin
        amp_d    = amp_q;
        // amp never exceeds vol in attack, but guard the subtraction anyway
        headroom = (amp_q >= vol) ? '0 : vol - amp_q;
        if (load) begin
            amp_d = (load_mode == ENV_ATTACK) ? '0 : load_vol;
        end else if (step_en) begin
            case (mode)
                ENV_DECAY:  amp_d = (amp_q > step) ? amp_q - step : '0;
                ENV_ATTACK: amp_d = (headroom > step) ? amp_q + step : vol;
                default:    amp_d = vol;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amp_q <= '0;
        end else begin
            amp_q <= amp_d;
        end
    end

    assign amp = amp_q;

endmodule

// File: rtl/square_duty_env.sv
// Pulse-wave channel with per-period envelope, note length and boundary-aligned reloads.
// Sample is registered-only (visible the cycle after start); no backpressure, done is a 1-cycle pulse.
module square_duty_env
    import square_pkg::*;
#(
    parameter int PERIOD_W = 21,
    parameter int SAMPLE_W = 16,
    parameter int LEN_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    square_duty_env_if.slave  bus
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_RUN  = RUN;
    localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
    localparam logic [LEN_W-1:0]    L_ONE = LEN_W'(1);

    logic [0:0]          state_q, state_d;
    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] act_q, act_d;
    logic [SAMPLE_W-1:0] vol_q, vol_d;
    logic [SAMPLE_W-1:0] step_q, step_d;
    logic [1:0]          mode_q, mode_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                done_q, done_d;
    logic                env_load, env_step_en, wrap;
    logic [SAMPLE_W-1:0] amp;

    assign wrap = (phase_q == per_q - P_ONE);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        per_d       = per_q;
        act_d       = act_q;
        vol_d       = vol_q;
        step_d      = step_q;
        mode_d      = mode_q;
        len_d       = len_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        env_load    = 1'b0;
        env_step_en = 1'b0;
        if (!bus.enable) begin
            state_d = S_IDLE;
        end else if (bus.start && bus.full_period != '0) begin
            state_d  = S_RUN;
            phase_d  = '0;
            per_d    = bus.full_period;
            act_d    = bus.active_period;
            vol_d    = bus.volume;
            step_d   = bus.env_step;
            mode_d   = bus.env_mode;
            len_d    = bus.length;
            rem_d    = bus.length;
            env_load = 1'b1;
        end else if (state_q == S_RUN) begin
            if (wrap) begin
                // Period boundary: the only point where timing and amplitude may change
                phase_d     = '0;
                per_d       = (bus.full_period != '0) ? bus.full_period : per_q;
                act_d       = bus.active_period;
                env_step_en = 1'b1;
                if (len_q != '0) begin
                    if (rem_q == L_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d = rem_q - L_ONE;
                    end
                end
            end else begin
                phase_d = phase_q + P_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            per_q   <= '0;
            act_q   <= '0;
            vol_q   <= '0;
            step_q  <= '0;
            mode_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            per_q   <= per_d;
            act_q   <= act_d;
            vol_q   <= vol_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    square_envelope #(.SAMPLE_W(SAMPLE_W)) u_env (
        .clk       (clk),
        .rst       (rst),
        .load      (env_load),
        .load_mode (bus.env_mode),
        .load_vol  (bus.volume),
        .step_en   (env_step_en),
        .mode      (mode_q),
        .vol       (vol_q),
        .step      (step_q),
        .amp       (amp)
    );

    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = done_q;
    assign bus.square_wave = (state_q == S_RUN && phase_q < act_q) ? amp : '0;

endmodule

// File: tb/tb_square_duty_env.sv
// Directed and random checks of square_duty_env against a period-count reference model.
module tb_square_duty_env;

    localparam int PW = 21;
    localparam int SW = 16;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    square_duty_env_if #(.PERIOD_W(PW), .SAMPLE_W(SW), .LEN_W(LW)) bus ();

    square_duty_env #(.PERIOD_W(PW), .SAMPLE_W(SW), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference: note position as (periods completed, cycle within period)
    bit m_run, m_done;
    int m_pos, m_per, m_act, m_vol, m_mode, m_step, m_len, m_n;

    function automatic int model_amp();
        longint d;
        d = longint'(m_n) * longint'(m_step);
        case (m_mode)
            1:       return (longint'(m_vol) > d) ? int'(longint'(m_vol) - d) : 0;
            2:       return (d < longint'(m_vol)) ? int'(d) : m_vol;
            default: return m_vol;
        endcase
    endfunction

    function automatic int model_wave();
        return (m_run && m_pos < m_act) ? model_amp() : 0;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_pos = 0; m_per = 0; m_act = 0;
        m_vol = 0; m_mode = 0; m_step = 0; m_len = 0; m_n = 0;
    endtask

    task automatic model_edge();
        m_done = 0;
        if (!bus.enable) begin
            m_run = 0;
        end else if (bus.start && bus.full_period != 0) begin
            m_run = 1; m_pos = 0; m_n = 0;
            m_per = int'(bus.full_period); m_act = int'(bus.active_period);
            m_vol = int'(bus.volume); m_mode = int'(bus.env_mode);
            m_step = int'(bus.env_step); m_len = int'(bus.length);
        end else if (m_run) begin
            if (m_pos + 1 >= m_per) begin
                m_pos = 0;
                m_n++;
                if (bus.full_period != 0) m_per = int'(bus.full_period);
                m_act = int'(bus.active_period);
                if (m_len != 0 && m_n == m_len) begin
                    m_run = 0;
                    m_done = 1;
                end
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", 32'(bus.busy), 32'(m_run));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("wave", 32'(bus.square_wave), 32'(model_wave()));
    endtask

    task automatic cfg(input int fp, input int ap, input int vol, input int mode,
                       input int step, input int len);
        bus.full_period   = fp[PW-1:0];
        bus.active_period = ap[PW-1:0];
        bus.volume        = vol[SW-1:0];
        bus.env_mode      = mode[1:0];
        bus.env_step      = step[SW-1:0];
        bus.length        = len[LW-1:0];
    endtask

    task automatic go_idle();
        bus.enable = 1'b0;
        bus.start  = 1'b0;
        cyc();
        bus.enable = 1'b1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    initial begin
        int dec_t[6];
        int att_t[5];
        int busy_cnt, done_cnt, done_at, nr, prev;
        int rise[4];
        dec_t = '{32'h100, 32'hC0, 32'h80, 32'h40, 32'h0, 32'h0};
        att_t = '{32'h0, 32'h30, 32'h60, 32'h64, 32'h64};

        rst = 1'b1;
        bus.enable = 1'b0;
        bus.start  = 1'b0;
        cfg(0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_wave", 32'(bus.square_wave), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.enable = 1'b1;
        cyc();

        // Constant tone
        cfg(10, 2, 32'hFF, 0, 0, 0);
        pulse_start();
        for (int i = 0; i < 30; i++) begin
            if (i > 0) cyc();
            chk("const_tone", 32'(bus.square_wave), (i % 10 < 2) ? 32'hFF : 32'h0);
        end
        go_idle();

        // Decay
        cfg(4, 2, 32'h100, 1, 32'h40, 0);
        pulse_start();
        for (int i = 0; i < 24; i++) begin
            if (i > 0) cyc();
            if (i % 4 == 0) chk("decay_amp", 32'(bus.square_wave), 32'(dec_t[i/4]));
        end
        go_idle();

        // Attack
        cfg(4, 2, 32'h64, 2, 32'h30, 0);
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (i > 0) cyc();
            if (i % 4 == 0) chk("attack_amp", 32'(bus.square_wave), 32'(att_t[i/4]));
        end
        go_idle();

        // Length
        cfg(5, 5, 32'h200, 0, 0, 3);
        pulse_start();
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) cyc();
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
            if (bus.done) done_at = i;
        end
        chk("len_busy_cycles", 32'(busy_cnt), 32'd15);
        chk("len_done_count", 32'(done_cnt), 32'd1);
        chk("len_done_at", 32'(done_at), 32'd15);
        chk("len_wave_after", 32'(bus.square_wave), 32'd0);

        // Mid-run period change, then full_period=0 keeps the last period
        cfg(10, 3, 32'h80, 0, 0, 0);
        pulse_start();
        nr = 0; prev = 1;
        rise = '{-1, -1, -1, -1};
        for (int i = 1; i <= 30; i++) begin
            if (i == 3) bus.full_period = 21'd6;
            if (i == 12) bus.full_period = 21'd0;
            cyc();
            if (bus.square_wave != 0 && prev == 0) begin
                if (nr < 4) rise[nr] = i;
                nr++;
            end
            prev = (bus.square_wave != 0) ? 1 : 0;
        end
        for (int k = 0; k < 4; k++) chk("period_rise", 32'(rise[k]), 32'(10 + 6 * k));
        go_idle();

        // Start coinciding with final wrap restarts without done
        cfg(5, 5, 32'h40, 0, 0, 2);
        pulse_start();
        for (int i = 1; i <= 9; i++) cyc();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("restart_done", 32'(bus.done), 32'd0);
        chk("restart_busy", 32'(bus.busy), 32'd1);
        done_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            done_cnt += int'(bus.done);
        end
        chk("restart_done_later", 32'(done_cnt), 32'd1);

        // Enable drop
        cfg(5, 3, 32'h40, 0, 0, 0);
        pulse_start();
        for (int i = 0; i < 3; i++) cyc();
        bus.enable = 1'b0;
        cyc();
        chk("en_drop_busy", 32'(bus.busy), 32'd0);
        chk("en_drop_done", 32'(bus.done), 32'd0);
        bus.enable = 1'b1;

        // per=1 attack with length
        cfg(1, 1, 32'h10, 2, 4, 3);
        pulse_start();
        for (int i = 0; i < 5; i++) cyc();

        // Async reset between edges
        cfg(4, 4, 32'h77, 0, 0, 0);
        pulse_start();
        cyc();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_wave", 32'(bus.square_wave), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        #1;
        rst = 1'b0;
        cyc();

        // Random stimulus
        for (int i = 0; i < 400; i++) begin
            bus.enable        = ($urandom_range(15) != 0);
            bus.start         = ($urandom_range(19) == 0);
            bus.full_period   = PW'($urandom_range(12));
            bus.active_period = PW'($urandom_range(14));
            bus.volume        = SW'($urandom);
            bus.env_mode      = 2'($urandom_range(3));
            bus.env_step      = SW'($urandom_range(16'h3000));
            bus.length        = LW'($urandom_range(4));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
